lbp_stream_rx: RTL and testbench
================================

LBP_STREAM_RX -- requirements
Module: lbp_stream_rx

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes, power of two, at least 2.
REQ-002 Parameter LEN_W, default 9: width of the frame byte counter.
REQ-003 clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 rst_n, input, 1: asynchronous, active-low reset.
REQ-005 s_valid, input, 1: incoming pixel strobe, driven from LBP out_valid; no backpressure.
REQ-006 s_data, input, 8: incoming pixel, driven from LBP out_image.
REQ-007 m_valid, output, 1: FIFO head is valid.
REQ-008 m_ready, input, 1: downstream accepts the head byte.
REQ-009 m_data, output, 8: FIFO head byte; 0 when the FIFO is empty.
REQ-010 frame_done, output, 1: one-cycle pulse at end of frame.
REQ-011 frame_len, output, LEN_W: byte count of the last completed frame.
REQ-012 frame_sum, output, 8: sum of the last completed frame's bytes, mod 256.
REQ-013 overflow, output, 1: sticky flag; a byte was dropped.

Function
REQ-014 Write: an s_valid cycle writes s_data into the FIFO if not full, or if full with a simultaneous read.
REQ-015 Read: an m_valid && m_ready cycle pops the head byte; m_valid == !empty.
REQ-016 No bypass: a byte written at edge N is visible on m_data/m_valid from edge N, i.e. one-cycle latency into an empty FIFO.
REQ-017 Full, s_valid, no read: the byte is dropped and overflow is set to 1 until reset; FIFO contents are unchanged.
REQ-018 Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - full = (MSBs differ) && (low bits equal).
  - empty = pointers equal.
REQ-019 FSM states are IDLE, RECV and DONE; the reset state is IDLE.
REQ-020 IDLE:
  - s_valid -> RECV, with cnt=1 and sum=s_data.
  - otherwise stay in IDLE.
REQ-021 RECV:
  - s_valid -> cnt+1, saturating at 2^LEN_W-1; sum+s_data mod 256; stay in RECV.
  - !s_valid -> DONE; latch frame_len=cnt and frame_sum=sum.
REQ-022 DONE:
  - frame_done=1 for exactly this cycle.
  - s_valid -> RECV, with cnt=1 and sum=s_data.
  - otherwise -> IDLE.
REQ-023 Dropped bytes (REQ-017) are still counted and summed.
REQ-024 frame_len and frame_sum hold their value until the next DONE.
REQ-025 The FIFO path and the frame FSM operate independently; m_ready has no effect on the FSM.

Reset
REQ-026 rst_n low forces all of the following, asynchronously, including mid-frame:
  - FSM to IDLE.
  - Pointers, cnt and sum to 0.
  - m_valid, m_data, frame_done, frame_len, frame_sum and overflow to 0.
REQ-027 FIFO storage is not reset; m_data is masked to 0 while empty.
REQ-028 After rst_n deasserts, the first s_valid cycle starts a new frame.

Structure
REQ-029 The shared package holds the FSM state enum (IDLE, RECV, DONE) and the DEPTH and LEN_W defaults.
REQ-030 The FIFO is one sub-module, lbp_rx_fifo, with write/read enables, full/empty flags and head data.
REQ-031 The FSM and the accumulators live in lbp_stream_rx.

Verification
REQ-032 Reset mid-frame: rst_n low after 3 bytes -> all outputs 0 immediately; the next frame reports its own length.
REQ-033 Basic frame, m_ready=1: 0x01,0x02,0x03,0xFF on 4 consecutive cycles, then idle.
  - m_data sequence is 0x01,0x02,0x03,0xFF.
  - frame_done pulses one cycle after the first idle cycle's edge.
  - frame_len=4, frame_sum=0x05.
REQ-034 Overflow: m_ready=0, 20 bytes 0x00..0x13.
  - overflow=1 from the 17th byte.
  - frame_len=20, frame_sum=0xBE.
  - Draining yields 0x00..0x0F, then m_valid=0.
REQ-035 Full with simultaneous read: FIFO full, then s_valid and m_ready both 1 for 8 cycles -> FIFO stays full, overflow stays 0, order is preserved.
REQ-036 Back-to-back frames: 2 bytes, 1 idle cycle, 3 bytes.
  - Two frame_done pulses, with frame_len=2 then 3.
  - If s_valid is high in DONE, the new frame starts with cnt=1.
REQ-037 Saturation: 600 consecutive bytes of 0x01 with m_ready=1 -> frame_len=511, frame_sum=0x58, no overflow.

Source files
------------

// File: rtl/lbp_stream_rx_pkg.sv
// lbp_stream_rx_pkg: shared frame-FSM state type and parameter defaults for the LBP stream receiver.
package lbp_stream_rx_pkg;
  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_LEN_W = 9;
endpackage

// File: rtl/lbp_rx_fifo.sv
// lbp_rx_fifo: byte FIFO with wrap-bit pointers, registered-write storage and a masked head output.
module lbp_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_wr_en,
  input  logic [7:0] i_wr_data,
  input  logic       i_rd_en,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_rd_data
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] r_wptr, r_rptr;
  logic [7:0]  r_mem [DEPTH];
  assign o_empty   = r_wptr == r_rptr;
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  // Storage carries no reset; the head is masked while empty instead.
  always_ff @(posedge clk)
    if (i_wr_en) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr_en) r_wptr <= r_wptr + 1'b1;
      if (i_rd_en) r_rptr <= r_rptr + 1'b1;
    end
endmodule

// File: rtl/lbp_stream_rx.sv
// lbp_stream_rx: buffers LBP output pixels in a FIFO and tracks per-frame byte count and checksum.
module lbp_stream_rx
  import lbp_stream_rx_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic [7:0]       frame_sum,
  output logic             overflow
);
  state_t           r_state, w_next;
  logic [LEN_W-1:0] r_cnt;
  logic [7:0]       r_sum;
  logic             r_overflow;
  logic             w_full, w_empty, w_wr_en, w_rd_en;
  assign w_rd_en = !w_empty && m_ready;
  assign w_wr_en = s_valid && (!w_full || w_rd_en);
  assign m_valid = !w_empty;
  assign overflow = r_overflow;
  lbp_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_data (s_data),
    .i_rd_en   (w_rd_en),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_rd_data (m_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_overflow <= 1'b0;
    else if (s_valid && w_full && !w_rd_en) r_overflow <= 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb w_next = s_valid ? RECV : (r_state == RECV ? DONE : IDLE);
  always_comb frame_done = r_state == DONE;
  // Accumulators see every strobe, including bytes the FIFO drops.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sum     <= '0;
      frame_len <= '0;
      frame_sum <= '0;
    end else begin
      if (s_valid) begin
        r_cnt <= r_state != RECV ? LEN_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
        r_sum <= r_state != RECV ? s_data : r_sum + s_data;
      end
      if (r_state == RECV && !s_valid) begin
        frame_len <= r_cnt;
        frame_sum <= r_sum;
      end
    end
endmodule

// File: tb/tb_lbp_stream_rx.sv
// tb_lbp_stream_rx: directed self-checking bench for lbp_stream_rx with default parameters.
module tb_lbp_stream_rx;
  logic       clk = 0, rst_n = 0, s_valid = 0, m_ready = 0;
  logic [7:0] s_data = 0;
  logic       m_valid, frame_done, overflow;
  logic [7:0] m_data, frame_sum;
  logic [8:0] frame_len;
  int         n_err = 0, n_chk = 0, n_done = 0, base = 0, d0 = 0;
  logic [7:0] q[$];
  lbp_stream_rx dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .frame_sum  (frame_sum),
    .overflow   (overflow)
  );
  always #5 clk = ~clk;
  // Pops and done pulses are observed mid-cycle, ahead of the edge that acts on them.
  always @(negedge clk) begin
    if (m_valid && m_ready) q.push_back(m_data);
    if (frame_done) n_done++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    s_valid = 0;
    m_ready = 0;
    rst_n   = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_frame_sum", frame_sum, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1;
    // basic frame with m_ready high
    m_ready = 1;
    base = q.size();
    drive(1, 8'h01); drive(1, 8'h02); drive(1, 8'h03); drive(1, 8'hFF);
    chk("basic_no_done_yet", frame_done, 0);
    drive(0, 0);
    chk("basic_done", frame_done, 1);
    chk("basic_len", frame_len, 4);
    chk("basic_sum", frame_sum, 8'h05);
    drive(0, 0);
    chk("basic_done_one_cycle", frame_done, 0);
    chk("basic_len_hold", frame_len, 4);
    chk("basic_pop_count", q.size() - base, 4);
    chk("basic_pop0", q[base], 8'h01);
    chk("basic_pop1", q[base+1], 8'h02);
    chk("basic_pop2", q[base+2], 8'h03);
    chk("basic_pop3", q[base+3], 8'hFF);
    chk("basic_empty_data", m_data, 0);
    // reset mid-frame
    m_ready = 0;
    drive(1, 8'hAA); drive(1, 8'hBB); drive(1, 8'hCC);
    chk("mid_m_valid_pre", m_valid, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_m_valid", m_valid, 0);
    chk("mid_m_data", m_data, 0);
    chk("mid_frame_len", frame_len, 0);
    chk("mid_frame_sum", frame_sum, 0);
    chk("mid_overflow", overflow, 0);
    @(posedge clk);
    #1 rst_n = 1;
    drive(1, 8'h10); drive(1, 8'h20); drive(0, 0);
    chk("mid_next_done", frame_done, 1);
    chk("mid_next_len", frame_len, 2);
    chk("mid_next_sum", frame_sum, 8'h30);
    // overflow with m_ready low
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, 8'(i));
      if (i == 15) chk("ovf_before_17th", overflow, 0);
      if (i == 16) chk("ovf_at_17th", overflow, 1);
    end
    chk("ovf_head_kept", m_data, 8'h00);
    drive(0, 0);
    chk("ovf_done", frame_done, 1);
    chk("ovf_len", frame_len, 20);
    chk("ovf_sum", frame_sum, 8'hBE);
    base = q.size();
    m_ready = 1;
    repeat (20) drive(0, 0);
    chk("ovf_drain_count", q.size() - base, 16);
    for (int i = 0; i < 16; i++) chk($sformatf("ovf_drain%0d", i), q[base+i], 32'(i));
    chk("ovf_drained_valid", m_valid, 0);
    chk("ovf_sticky", overflow, 1);
    // full FIFO with simultaneous read and write
    do_reset();
    base = q.size();
    for (int i = 0; i < 16; i++) drive(1, 8'(8'h20 + i));
    chk("full_head", m_data, 8'h20);
    m_ready = 1;
    for (int i = 0; i < 8; i++) drive(1, 8'(8'h30 + i));
    chk("full_rw_no_ovf", overflow, 0);
    m_ready = 0;
    drive(1, 8'h38);
    chk("full_still_full", overflow, 1);
    m_ready = 1;
    repeat (20) drive(0, 0);
    chk("full_pop_count", q.size() - base, 24);
    for (int i = 0; i < 24; i++) chk($sformatf("full_order%0d", i), q[base+i], 32'(8'h20 + i));
    // back-to-back frames
    do_reset();
    m_ready = 1;
    d0 = n_done;
    drive(1, 8'h10); drive(1, 8'h20); drive(0, 0);
    chk("b2b_done1", frame_done, 1);
    chk("b2b_len1", frame_len, 2);
    chk("b2b_sum1", frame_sum, 8'h30);
    drive(1, 8'h01);
    chk("b2b_restart_no_done", frame_done, 0);
    chk("b2b_len1_hold", frame_len, 2);
    drive(1, 8'h02); drive(1, 8'h03); drive(0, 0);
    chk("b2b_done2", frame_done, 1);
    chk("b2b_len2", frame_len, 3);
    chk("b2b_sum2", frame_sum, 8'h06);
    drive(0, 0); drive(0, 0);
    chk("b2b_pulses", n_done - d0, 2);
    // counter saturation
    do_reset();
    m_ready = 1;
    repeat (600) drive(1, 8'h01);
    drive(0, 0);
    chk("sat_done", frame_done, 1);
    chk("sat_len", frame_len, 511);
    chk("sat_sum", frame_sum, 8'h58);
    chk("sat_no_ovf", overflow, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
